// File: rtl/pool_layer_ctrl.sv
// ============================================================================
// pool_layer_ctrl
// ----------------------------------------------------------------------------
// Sequencer for a 2x2, stride-2 max-pool layer. It streams one feature map
// row-major from the source buffer into the PE-array pool line buffer, then
// writes each pooled result into the destination buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle pulse, latches config (ignored while busy)
//   src_sel                   1: read buf1 / write buf2, 0: read buf2 / write buf1
//   in_rows, in_cols          input map dimensions
//   src_base, dst_base        first read / first write address
//   busy, done                layer in progress / one-cycle completion pulse
//   aybz_azby_pool            buffer swap select (latched src_sel)
//   buf{1,2}_r_en/_r_addr     buffer read controls
//   buf{1,2}_w_en/_w_addr     buffer write controls
//   shifting_line_pool        shift one pixel into the pool line buffer
//   line_buffer_reset_pool    clear the pool line buffer
//   row_length_pool           latched in_cols
//   cycle_count               busy-cycle counter (optional)
//
// Optional feature: define POOL_CYCLE_CNT_EN to build the busy-cycle counter;
// otherwise cycle_count is tied to 0.
// ============================================================================
module pool_layer_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DIM_W   = 8,
    parameter int RD_LAT  = 1,
    parameter int PEA_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              src_sel,
    input  logic [DIM_W-1:0]  in_rows,
    input  logic [DIM_W-1:0]  in_cols,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              aybz_azby_pool,
    output logic              buf1_r_en,
    output logic              buf2_r_en,
    output logic [ADDR_W-1:0] buf1_r_addr,
    output logic [ADDR_W-1:0] buf2_r_addr,
    output logic              buf1_w_en,
    output logic              buf2_w_en,
    output logic [ADDR_W-1:0] buf1_w_addr,
    output logic [ADDR_W-1:0] buf2_w_addr,
    output logic              shifting_line_pool,
    output logic              line_buffer_reset_pool,
    output logic [DIM_W-1:0]  row_length_pool,
    output logic [31:0]       cycle_count
);

    localparam int DRAIN_LEN = RD_LAT + PEA_LAT;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic                busy_q;
    logic                done_q;
    logic                lbr_q;
    logic                sel_q;
    logic [DIM_W-1:0]    rows_q;
    logic [DIM_W-1:0]    cols_q;
    logic                rd_active;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DIM_W-1:0]    rd_row;
    logic [DIM_W-1:0]    rd_col;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic                accept;
    logic                last_pixel;
    logic                rd_win;

    logic [RD_LAT-1:0]   sh_vld;
    logic [RD_LAT-1:0]   sh_win;
    logic [PEA_LAT-1:0]  wr_pipe;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_fire;

    assign accept     = (state == S_IDLE) && start;
    assign last_pixel = (rd_row == rows_q - DIM_W'(1)) && (rd_col == cols_q - DIM_W'(1));
    // A read at odd row and odd column is the bottom-right pixel of a window.
    assign rd_win     = rd_active && rd_row[0] && rd_col[0];

    // Layer sequencing. The read address is preloaded with src_base at start
    // and simply increments while streaming, so it wraps mod 2^ADDR_W for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lbr_q     <= 1'b0;
            sel_q     <= 1'b0;
            rows_q    <= '0;
            cols_q    <= '0;
            rd_active <= 1'b0;
            rd_addr   <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_q   <= src_sel;
                        rows_q  <= in_rows;
                        cols_q  <= in_cols;
                        rd_addr <= src_base;
                        busy_q  <= 1'b1;
                        if ((in_rows < DIM_W'(2)) || (in_cols < DIM_W'(2))) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_CLEAR;
                            lbr_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    lbr_q     <= 1'b0;
                    rd_active <= 1'b1;
                    rd_row    <= '0;
                    rd_col    <= '0;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (last_pixel) begin
                        rd_active <= 1'b0;
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_col == cols_q - DIM_W'(1)) begin
                            rd_col <= '0;
                            rd_row <= rd_row + DIM_W'(1);
                        end else begin
                            rd_col <= rd_col + DIM_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Covers the read latency plus PE-array latency of the last window.
                    if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel and write pipelines: the read is delayed RD_LAT cycles to form the
    // shift strobe, and a window-closing shift is delayed PEA_LAT more cycles
    // to form the write strobe. The write address counts up from dst_base.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld  <= '0;
            sh_win  <= '0;
            wr_pipe <= '0;
            wr_addr <= '0;
        end else begin
            sh_vld[0] <= rd_active;
            sh_win[0] <= rd_win;
            for (int i = 1; i < RD_LAT; i++) begin
                sh_vld[i] <= sh_vld[i-1];
                sh_win[i] <= sh_win[i-1];
            end
            wr_pipe[0] <= sh_win[RD_LAT-1];
            for (int i = 1; i < PEA_LAT; i++) begin
                wr_pipe[i] <= wr_pipe[i-1];
            end
            if (accept) begin
                wr_addr <= dst_base;
            end else if (wr_fire) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

    assign wr_fire = wr_pipe[PEA_LAT-1];

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign aybz_azby_pool         = sel_q;
    assign row_length_pool        = cols_q;
    assign line_buffer_reset_pool = lbr_q;
    assign shifting_line_pool     = sh_vld[RD_LAT-1];

    assign buf1_r_en   = rd_active && sel_q;
    assign buf2_r_en   = rd_active && !sel_q;
    assign buf1_r_addr = buf1_r_en ? rd_addr : '0;
    assign buf2_r_addr = buf2_r_en ? rd_addr : '0;

    // The destination is always the buffer not being read.
    assign buf1_w_en   = wr_fire && !sel_q;
    assign buf2_w_en   = wr_fire && sel_q;
    assign buf1_w_addr = buf1_w_en ? wr_addr : '0;
    assign buf2_w_addr = buf2_w_en ? wr_addr : '0;

`ifdef POOL_CYCLE_CNT_EN
    logic [31:0] cnt_q;

    // Counts busy cycles of the current layer; holds after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// ============================================================================
// tb_pool_layer_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for pool_layer_ctrl. Each scenario pushes its expected
// reads, writes, shifts, line-buffer clears and done pulse (with the cycle,
// relative to the start pulse, at which each must appear) into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents one.
// ============================================================================
module tb_pool_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        src_sel;
    logic [7:0]  in_rows;
    logic [7:0]  in_cols;
    logic [11:0] src_base;
    logic [11:0] dst_base;
    logic        busy;
    logic        done;
    logic        aybz_azby_pool;
    logic        buf1_r_en;
    logic        buf2_r_en;
    logic [11:0] buf1_r_addr;
    logic [11:0] buf2_r_addr;
    logic        buf1_w_en;
    logic        buf2_w_en;
    logic [11:0] buf1_w_addr;
    logic [11:0] buf2_w_addr;
    logic        shifting_line_pool;
    logic        line_buffer_reset_pool;
    logic [7:0]  row_length_pool;
    logic [31:0] cycle_count;

    pool_layer_ctrl #(
        .ADDR_W(12), .DIM_W(8), .RD_LAT(1), .PEA_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_sel(src_sel),
        .in_rows(in_rows),
        .in_cols(in_cols),
        .src_base(src_base),
        .dst_base(dst_base),
        .busy(busy),
        .done(done),
        .aybz_azby_pool(aybz_azby_pool),
        .buf1_r_en(buf1_r_en),
        .buf2_r_en(buf2_r_en),
        .buf1_r_addr(buf1_r_addr),
        .buf2_r_addr(buf2_r_addr),
        .buf1_w_en(buf1_w_en),
        .buf2_w_en(buf2_w_en),
        .buf1_w_addr(buf1_w_addr),
        .buf2_w_addr(buf2_w_addr),
        .shifting_line_pool(shifting_line_pool),
        .line_buffer_reset_pool(line_buffer_reset_pool),
        .row_length_pool(row_length_pool),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rel;
        int bufid;
        int addr;
    } ev_t;

    ev_t exp_rd[$];
    ev_t exp_wr[$];
    int  exp_sh[$];
    int  exp_lbr[$];
    int  exp_done[$];

    int cyc = 0;
    int start_cyc = 0;
    bit mon_en = 1'b0;
    int n_pass = 0;
    int n_total = 0;

`ifdef POOL_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc - start_cyc);
    endtask

    function automatic int expCount(input int c);
        return CNT_ON ? c : 0;
    endfunction

    task automatic popRd(input int bufid, input int addr, input int rel);
        ev_t e;
        if (exp_rd.size() == 0) begin
            checkOutput("rd_unexpected_buf", bufid, 0);
        end else begin
            e = exp_rd.pop_front();
            checkOutput("rd_cycle", rel, e.rel);
            checkOutput("rd_buf", bufid, e.bufid);
            checkOutput("rd_addr", addr, e.addr);
        end
    endtask

    task automatic popWr(input int bufid, input int addr, input int rel);
        ev_t e;
        if (exp_wr.size() == 0) begin
            checkOutput("wr_unexpected_buf", bufid, 0);
        end else begin
            e = exp_wr.pop_front();
            checkOutput("wr_cycle", rel, e.rel);
            checkOutput("wr_buf", bufid, e.bufid);
            checkOutput("wr_addr", addr, e.addr);
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the queues.
    always @(negedge clk) begin : monitor
        int rel;
        int idle_addr;
        if (mon_en) begin
            rel = cyc - start_cyc;
            if (buf1_r_en) popRd(1, int'(buf1_r_addr), rel);
            if (buf2_r_en) popRd(2, int'(buf2_r_addr), rel);
            if (buf1_w_en) popWr(1, int'(buf1_w_addr), rel);
            if (buf2_w_en) popWr(2, int'(buf2_w_addr), rel);
            if (shifting_line_pool) begin
                if (exp_sh.size() == 0) checkOutput("sh_unexpected_cycle", rel, -1);
                else checkOutput("sh_cycle", rel, exp_sh.pop_front());
            end
            if (line_buffer_reset_pool) begin
                if (exp_lbr.size() == 0) checkOutput("lbr_unexpected_cycle", rel, -1);
                else checkOutput("lbr_cycle", rel, exp_lbr.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) checkOutput("done_unexpected_cycle", rel, -1);
                else checkOutput("done_cycle", rel, exp_done.pop_front());
            end
            idle_addr = (buf1_r_en ? 0 : int'(buf1_r_addr)) | (buf2_r_en ? 0 : int'(buf2_r_addr)) |
                        (buf1_w_en ? 0 : int'(buf1_w_addr)) | (buf2_w_en ? 0 : int'(buf2_w_addr));
            checkOutput("idle_addr", idle_addr, 0);
        end
    end

    task automatic pushReads(input int n, input int bufid, input int base);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back('{2 + k, bufid, (base + k) % 4096});
            exp_sh.push_back(3 + k);
        end
    endtask

    task automatic pushCaseA();
        exp_lbr.push_back(1);
        pushReads(16, 1, 0);
        exp_wr.push_back('{10, 2, 12'h100});
        exp_wr.push_back('{12, 2, 12'h101});
        exp_wr.push_back('{18, 2, 12'h102});
        exp_wr.push_back('{20, 2, 12'h103});
        exp_done.push_back(21);
    endtask

    task automatic applyStimulus(input int rows, input int cols, input bit sel,
                                 input int sbase, input int dbase);
        @(posedge clk); #1;
        in_rows   = 8'(rows);
        in_cols   = 8'(cols);
        src_sel   = sel;
        src_base  = 12'(sbase);
        dst_base  = 12'(dbase);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_done.size() == 0) break;
        end
        checkOutput("done_pending", exp_done.size(), 0);
    endtask

    task automatic checkEmpty();
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rd_left", exp_rd.size(), 0);
        checkOutput("wr_left", exp_wr.size(), 0);
        checkOutput("sh_left", exp_sh.size(), 0);
        checkOutput("lbr_left", exp_lbr.size(), 0);
        checkOutput("done_left", exp_done.size(), 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_sh.delete();
        exp_lbr.delete();
        exp_done.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_enables"},
                    int'({buf1_r_en, buf2_r_en, buf1_w_en, buf2_w_en,
                          shifting_line_pool, line_buffer_reset_pool}), 0);
        checkOutput({tag, "_aybz"}, int'(aybz_azby_pool), 0);
        checkOutput({tag, "_row_len"}, int'(row_length_pool), 0);
        checkOutput({tag, "_cycle_count"}, int'(cycle_count), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; src_sel = 1'b0;
        in_rows = '0; in_cols = '0; src_base = '0; dst_base = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        $display("[TB] Case A: 4x4, buf1 -> buf2");
        pushCaseA();
        applyStimulus(4, 4, 1'b1, 0, 12'h100);
        waitDone(60);
        checkEmpty();
        checkOutput("caseA_busy", int'(busy), 0);
        checkOutput("caseA_aybz", int'(aybz_azby_pool), 1);
        checkOutput("caseA_row_len", int'(row_length_pool), 4);
        checkOutput("caseA_cycle_count", int'(cycle_count), expCount(21));

        $display("[TB] 5x3, buf2 -> buf1");
        exp_lbr.push_back(1);
        pushReads(15, 2, 12'h020);
        exp_wr.push_back('{9, 1, 12'h007});
        exp_wr.push_back('{15, 1, 12'h008});
        exp_done.push_back(20);
        applyStimulus(5, 3, 1'b0, 12'h020, 12'h007);
        waitDone(60);
        checkEmpty();
        checkOutput("odd_aybz", int'(aybz_azby_pool), 0);
        checkOutput("odd_row_len", int'(row_length_pool), 3);
        checkOutput("odd_cycle_count", int'(cycle_count), expCount(20));

        $display("[TB] 1x8 degenerate map");
        exp_done.push_back(1);
        applyStimulus(1, 8, 1'b1, 12'h010, 12'h200);
        waitDone(20);
        checkEmpty();
        checkOutput("tiny_aybz", int'(aybz_azby_pool), 1);
        checkOutput("tiny_row_len", int'(row_length_pool), 8);
        checkOutput("tiny_cycle_count", int'(cycle_count), expCount(1));

        $display("[TB] 2x2 with address wrap and a start during STREAM");
        exp_lbr.push_back(1);
        exp_rd.push_back('{2, 1, 12'hFFE});
        exp_rd.push_back('{3, 1, 12'hFFF});
        exp_rd.push_back('{4, 1, 12'h000});
        exp_rd.push_back('{5, 1, 12'h001});
        for (int s = 3; s <= 6; s++) exp_sh.push_back(s);
        exp_wr.push_back('{8, 2, 12'h0AB});
        exp_done.push_back(9);
        applyStimulus(2, 2, 1'b1, 12'hFFE, 12'h0AB);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_rows = 8'd4; in_cols = 8'd4; src_sel = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(40);
        checkEmpty();
        checkOutput("wrap_row_len", int'(row_length_pool), 2);
        checkOutput("wrap_cycle_count", int'(cycle_count), expCount(9));

        $display("[TB] Case A aborted by reset at cycle 8");
        exp_lbr.push_back(1);
        pushReads(7, 1, 0);
        exp_sh.delete();
        for (int s = 3; s <= 8; s++) exp_sh.push_back(s);
        applyStimulus(4, 4, 1'b1, 0, 12'h100);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkIdleOutputs("abort");
        repeat (30) @(posedge clk);
        checkEmpty();

        $display("[TB] Case A rerun after reset");
        pushCaseA();
        applyStimulus(4, 4, 1'b1, 0, 12'h100);
        waitDone(60);
        checkEmpty();
        checkOutput("rerun_aybz", int'(aybz_azby_pool), 1);
        checkOutput("rerun_cycle_count", int'(cycle_count), expCount(21));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pool_layer_ctrl.md
Name: pool_layer_ctrl

Overview:
- Sequencer for 2x2, stride-2 max-pool layers; it produces the pool-path control set consumed by the buffer/PE-array mux when comp_sel = 3'b011.
- Streams one feature map row-major from the source buffer into the PE-array pool line buffer, then writes pooled results into the destination buffer.
- Drives the buffer swap select (aybz_azby_pool), read/write enables and addresses for both buffers, and the PE-array pool controls.

Parameters:
- ADDR_W, 12, buffer address width; all address arithmetic is mod 2^ADDR_W.
- DIM_W, 8, width of row/column counts.
- RD_LAT, 1, buffer read latency in cycles (r_en to data on m1_output_bus).
- PEA_LAT, 2, cycles from shifting_line_pool of the window's last pixel to the pooled result being valid on output_bus1_PEA.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches config; ignored while busy
- src_sel  in  1  1: read buf1, write buf2; 0: read buf2, write buf1
- in_rows  in  DIM_W  input map rows
- in_cols  in  DIM_W  input map columns
- src_base  in  ADDR_W  first read address
- dst_base  in  ADDR_W  first write address
- busy  out  1  layer in progress
- done  out  1  one-cycle completion pulse
- aybz_azby_pool  out  1  equals latched src_sel
- buf1_r_en, buf2_r_en  out  1 each  read enables
- buf1_r_addr, buf2_r_addr  out  ADDR_W each  read addresses; the integration replicates them to all N_BUF banks
- buf1_w_en, buf2_w_en  out  1 each  write enables
- buf1_w_addr, buf2_w_addr  out  ADDR_W each  write addresses
- shifting_line_pool  out  1  shift one pixel into the pool line buffer
- line_buffer_reset_pool  out  1  clear the pool line buffer
- row_length_pool  out  DIM_W  latched in_cols
- cycle_count  out  32  see Optional Feature

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all delay pipelines are flushed. Reset mid-layer aborts the layer with no done pulse.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: on start, latch all config inputs.
  - If in_rows < 2 or in_cols < 2, go to DONE (no reads, no writes).
  - Otherwise go to CLEAR.
- CLEAR: lasts one cycle; line_buffer_reset_pool = 1. Then go to STREAM.
- STREAM: issues N = in_rows*in_cols reads on consecutive cycles.
  - Read k (k = 0..N-1) asserts the source r_en with r_addr = src_base + k. The non-source r_en stays 0.
  - After the read with k = N-1, go to DRAIN.
- Pixel pipeline: shifting_line_pool is r_en delayed by RD_LAT, with the pixel row/column carried alongside.
- Write generation: a shifted pixel at odd row and odd column (0-based) closes a window.
  - Its write fires PEA_LAT cycles after that shift: destination w_en = 1, w_addr = dst_base + j, where j counts writes from 0.
  - The non-destination w_en stays 0.
  - With odd in_rows or in_cols, the trailing row/column is read and shifted but produces no writes.
  - Total writes = floor(R/2)*floor(C/2).
- DRAIN: lasts exactly RD_LAT+PEA_LAT cycles, then go to DONE.
- DONE: lasts one cycle; done = 1. Then go to IDLE.
- busy is 1 in CLEAR, STREAM, DRAIN and DONE; it is 0 in IDLE.
- Idle address outputs: all addresses are 0 whenever the matching enable is 0.
- Output registration: aybz_azby_pool and row_length_pool are registered, valid from CLEAR onward, and hold their values after done until the next start.
- Overlap: a start arriving in the same cycle as done is ignored.
- Address wrap: src_base + k and dst_base + j wrap mod 2^ADDR_W with no error.

Optional Feature:
- Macro POOL_CYCLE_CNT_EN.
- Defined:
  - cycle_count clears to 0 on an accepted start and increments every cycle busy = 1.
  - It holds its value after done until the next start; reset clears it to 0.
- Undefined: cycle_count is the constant 0 and no counter logic is built.

Test Plan:
- Case A setup for the first two scenarios: 4x4, src_sel = 1, src_base = 0, dst_base = 0x100, RD_LAT = 1, PEA_LAT = 2, start at cycle 0.
- Case A sequencing: line_buffer_reset_pool at cycle 1; buf1_r_en at cycles 2-17 with addr 0-15; shifting_line_pool at cycles 3-18; buf2_w_en at cycles 10, 12, 18, 20 with addr 0x100-0x103; done at cycle 21; buf1_w_en and buf2_r_en never asserted.
- Case A counter: POOL_CYCLE_CNT_EN defined -> cycle_count = 21 after done. Undefined -> cycle_count = 0 throughout.
- 5x3, src_sel = 0, dst_base = 0x7 -> 15 buf2 reads; exactly 2 buf1 writes, at addr 0x7 and 0x8, from pixels (1,1) and (3,1); row 4 and column 2 produce no writes; aybz_azby_pool = 0.
- in_rows = 1, in_cols = 8 -> done the cycle after the start is accepted; no r_en, w_en or line_buffer_reset_pool asserted.
- src_base = 0xFFE, 2x2 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001; one write; a second start pulse during STREAM is ignored, giving still 4 reads and one done.
- rst asserted at cycle 8 of Case A -> from the next cycle all outputs are 0 and busy = 0; no writes and no done follow; a new start runs a full Case A sequence.
